// File: rtl/load_store_unit_if.sv
// Execute-stage, data-memory and writeback signals of the load/store unit.
// master: the load/store unit itself; slave: the surrounding pipeline and memory.
interface load_store_unit_if;
  localparam int unsigned XLEN = 32;
  localparam int unsigned REGW = 5;
  localparam int unsigned F3W  = 3;
  localparam int unsigned BEW  = XLEN / 8;

  logic            i_valid;
  logic            o_ready;
  logic [XLEN-1:0] i_addr;
  logic [XLEN-1:0] i_wdata;
  logic [F3W-1:0]  i_func3;
  logic            i_load;
  logic            i_store;
  logic [REGW-1:0] i_rd;

  logic            o_mem_req;
  logic            o_mem_we;
  logic [XLEN-1:0] o_mem_addr;
  logic [XLEN-1:0] o_mem_wdata;
  logic [BEW-1:0]  o_mem_be;
  logic            i_mem_ack;
  logic [XLEN-1:0] i_mem_rdata;

  logic            o_wb_valid;
  logic [XLEN-1:0] o_wb_data;
  logic [REGW-1:0] o_wb_rd;
  logic            o_misalign;

  modport master (
    input  i_valid, i_addr, i_wdata, i_func3, i_load, i_store, i_rd,
    input  i_mem_ack, i_mem_rdata,
    output o_ready, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
    output o_wb_valid, o_wb_data, o_wb_rd, o_misalign
  );

  modport slave (
    output i_valid, i_addr, i_wdata, i_func3, i_load, i_store, i_rd,
    output i_mem_ack, i_mem_rdata,
    input  o_ready, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
    input  o_wb_valid, o_wb_data, o_wb_rd, o_misalign
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: IDLE -> REQ -> RESP sequencer between execute, data memory and writeback.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses; otherwise low bits are ignored.
module load_store_unit (
  input  logic              i_clk,
  input  logic              i_reset,
  load_store_unit_if.master bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned REGW = 5;
  localparam int unsigned F3W  = 3;
  localparam int unsigned BEW  = XLEN / 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]      state_q,     state_d;
  logic            ready_q,     ready_d;
  logic            mem_req_q,   mem_req_d;
  logic            mem_we_q,    mem_we_d;
  logic [XLEN-1:0] mem_addr_q,  mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [BEW-1:0]  mem_be_q,    mem_be_d;
  logic            wb_valid_q,  wb_valid_d;
  logic [XLEN-1:0] wb_data_q,   wb_data_d;
  logic [REGW-1:0] wb_rd_q,     wb_rd_d;
  logic            misalign_q,  misalign_d;
  logic [F3W-1:0]  f3_q,        f3_d;
  logic [1:0]      lo_q,        lo_d;
  logic [REGW-1:0] rd_q,        rd_d;

  logic            acc_load_c;
  logic            acc_store_c;
  logic            misalign_c;
  logic [BEW-1:0]  st_be_c;
  logic [XLEN-1:0] st_data_c;
  logic [7:0]      ld_byte_c;
  logic [15:0]     ld_half_c;
  logic [XLEN-1:0] ld_data_c;

  // Load wins when both class bits are set.
  assign acc_load_c  = bus.i_load;
  assign acc_store_c = bus.i_store & ~bus.i_load;

`ifdef LSU_MISALIGN_TRAP_EN
  // Halfwords need addr[0]=0; words (including undefined codes) need addr[1:0]=0.
  always_comb begin
    case (bus.i_func3[1:0])
      2'b00:   misalign_c = 1'b0;
      2'b01:   misalign_c = bus.i_addr[0];
      default: misalign_c = |bus.i_addr[1:0];
    endcase
  end
`else
  assign misalign_c = 1'b0;
`endif

  // Store lane replication and byte enables.
  always_comb begin
    case (bus.i_func3[1:0])
      2'b00: begin
        st_be_c   = BEW'(4'b0001 << bus.i_addr[1:0]);
        st_data_c = {4{bus.i_wdata[7:0]}};
      end
      2'b01: begin
        st_be_c   = bus.i_addr[1] ? 4'b1100 : 4'b0011;
        st_data_c = {2{bus.i_wdata[15:0]}};
      end
      default: begin
        st_be_c   = 4'b1111;
        st_data_c = bus.i_wdata;
      end
    endcase
  end

  // Load lane selection and extension from the read data present at ack.
  always_comb begin
    case (lo_q)
      2'd0:    ld_byte_c = bus.i_mem_rdata[7:0];
      2'd1:    ld_byte_c = bus.i_mem_rdata[15:8];
      2'd2:    ld_byte_c = bus.i_mem_rdata[23:16];
      default: ld_byte_c = bus.i_mem_rdata[31:24];
    endcase
    ld_half_c = lo_q[1] ? bus.i_mem_rdata[31:16] : bus.i_mem_rdata[15:0];
    case (f3_q[1:0])
      2'b00:   ld_data_c = f3_q[2] ? {24'd0, ld_byte_c} : {{24{ld_byte_c[7]}}, ld_byte_c};
      2'b01:   ld_data_c = f3_q[2] ? {16'd0, ld_half_c} : {{16{ld_half_c[15]}}, ld_half_c};
      default: ld_data_c = bus.i_mem_rdata;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    wb_valid_d  = 1'b0;
    wb_data_d   = wb_data_q;
    wb_rd_d     = wb_rd_q;
    misalign_d  = 1'b0;
    f3_d        = f3_q;
    lo_d        = lo_q;
    rd_d        = rd_q;

    case (state_q)
      S_IDLE: begin
        if (bus.i_valid) begin
          f3_d = bus.i_func3;
          lo_d = bus.i_addr[1:0];
          rd_d = bus.i_rd;
          if ((acc_load_c | acc_store_c) && misalign_c) begin
            state_d    = S_RESP;
            wb_valid_d = 1'b1;
            wb_rd_d    = '0;
            misalign_d = 1'b1;
          end else if (acc_load_c | acc_store_c) begin
            state_d     = S_REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = acc_store_c;
            mem_addr_d  = {bus.i_addr[XLEN-1:2], 2'b00};
            mem_be_d    = acc_store_c ? st_be_c : 4'b1111;
            mem_wdata_d = acc_store_c ? st_data_c : '0;
          end else begin
            state_d    = S_RESP;
            wb_valid_d = 1'b1;
            wb_data_d  = bus.i_addr;
            wb_rd_d    = bus.i_rd;
          end
        end
      end
      S_REQ: begin
        if (bus.i_mem_ack) begin
          state_d    = S_RESP;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          wb_valid_d = 1'b1;
          if (mem_we_q) begin
            wb_rd_d = '0;
          end else begin
            wb_data_d = ld_data_c;
            wb_rd_d   = rd_q;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      wb_valid_q  <= 1'b0;
      wb_data_q   <= '0;
      wb_rd_q     <= '0;
      misalign_q  <= 1'b0;
      f3_q        <= '0;
      lo_q        <= '0;
      rd_q        <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      wb_valid_q  <= wb_valid_d;
      wb_data_q   <= wb_data_d;
      wb_rd_q     <= wb_rd_d;
      misalign_q  <= misalign_d;
      f3_q        <= f3_d;
      lo_q        <= lo_d;
      rd_q        <= rd_d;
    end
  end

  assign bus.o_ready     = ready_q;
  assign bus.o_mem_req   = mem_req_q;
  assign bus.o_mem_we    = mem_we_q;
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_mem_wdata = mem_wdata_q;
  assign bus.o_mem_be    = mem_be_q;
  assign bus.o_wb_valid  = wb_valid_q;
  assign bus.o_wb_data   = wb_data_q;
  assign bus.o_wb_rd     = wb_rd_q;
  // Constant zero unless the trap build can set it.
  assign bus.o_misalign  = misalign_q;
endmodule
